// File: rtl/i2c_target_regs.sv
// I2C target with an 8 x 8-bit register file and an auto-incrementing pointer.
// SCL/SDA are oversampled by i_clk; SDA is driven open-drain through o_sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] P_ADDR = 7'h2A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_start_det,
  output logic       o_stop_det,
  output logic       o_wr_en,
  output logic [2:0] o_wr_ptr,
  output logic [7:0] o_wr_data
);

  localparam int unsigned DW   = 8;
  localparam int unsigned PW   = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  logic scl_m, scl_s, scl_h;
  logic sda_m, sda_s, sda_h;
  logic ev_rise, ev_fall, ev_start, ev_stop, ev_sda;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [DW-1:0]   shreg;
  logic [PW-1:0]   ptr;
  logic            rw;
  logic            phase;
  logic [DW-1:0]   regs [NREG];

  logic [DW-1:0]   rx_byte_c;
  logic            last_bit_c;

  assign rx_byte_c  = {shreg[DW-2:0], ev_sda};
  assign last_bit_c = (bit_cnt == CW'(DW - 1));

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_h <= 1'b1;
      sda_m <= 1'b1; sda_s <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_m <= i_scl; scl_s <= scl_m; scl_h <= scl_s;
      sda_m <= i_sda; sda_s <= sda_m; sda_h <= sda_s;
    end
  end

  // Registered bus events; SDA moving while SCL is stable-high is START/STOP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      ev_sda   <= 1'b1;
    end else begin
      ev_rise  <= scl_s & ~scl_h;
      ev_fall  <= ~scl_s & scl_h;
      ev_start <= scl_s & scl_h & ~sda_s & sda_h;
      ev_stop  <= scl_s & scl_h & sda_s & ~sda_h;
      ev_sda   <= sda_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      phase       <= 1'b0;
      o_sda_oe    <= 1'b0;
      o_busy      <= 1'b0;
      o_start_det <= 1'b0;
      o_stop_det  <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_ptr    <= '0;
      o_wr_data   <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      o_start_det <= 1'b0;
      o_stop_det  <= 1'b0;
      o_wr_en     <= 1'b0;
      if (ev_start) begin
        state       <= S_ADDR;
        bit_cnt     <= '0;
        o_sda_oe    <= 1'b0;
        o_busy      <= 1'b1;
        o_start_det <= 1'b1;
      end else if (ev_stop) begin
        state      <= S_IDLE;
        o_sda_oe   <= 1'b0;
        o_busy     <= 1'b0;
        o_stop_det <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ADDR, S_PTR, S_WDATA: begin
            if (ev_rise) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt + CW'(1);
              if (last_bit_c) begin
                phase <= 1'b0;
                if (state == S_ADDR) begin
                  rw    <= ev_sda;
                  state <= (rx_byte_c[DW-1:1] == P_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                end else if (state == S_PTR) begin
                  ptr   <= rx_byte_c[PW-1:0];
                  state <= S_PTR_ACK;
                end else begin
                  regs[ptr] <= rx_byte_c;
                  o_wr_en   <= 1'b1;
                  o_wr_ptr  <= ptr;
                  o_wr_data <= rx_byte_c;
                  ptr       <= ptr + PW'(1);
                  state     <= S_WACK;
                end
              end
            end
          end
          // ACK slot: pull low on the first fall, hand over on the second.
          S_ADDR_ACK, S_PTR_ACK, S_WACK: begin
            if (ev_fall) begin
              if (!phase) begin
                o_sda_oe <= 1'b1;
                phase    <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (state == S_ADDR_ACK && rw) begin
                  shreg    <= regs[ptr];
                  o_sda_oe <= ~regs[ptr][DW-1];
                  state    <= S_RDATA;
                end else begin
                  o_sda_oe <= 1'b0;
                  state    <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          // Rotate on the rise so shreg[7] always holds the next bit to drive.
          S_RDATA: begin
            if (ev_rise) begin
              bit_cnt <= bit_cnt + CW'(1);
              shreg   <= {shreg[DW-2:0], shreg[DW-1]};
            end else if (ev_fall) begin
              if (bit_cnt == CW'(DW)) begin
                o_sda_oe <= 1'b0;
                phase    <= 1'b0;
                state    <= S_RACK;
              end else begin
                o_sda_oe <= ~shreg[DW-1];
              end
            end
          end
          S_RACK: begin
            if (ev_rise) begin
              if (!ev_sda) begin
                ptr   <= ptr + PW'(1);
                phase <= 1'b1;
              end else begin
                state <= S_WAIT_STOP;
              end
            end else if (ev_fall && phase) begin
              bit_cnt  <= '0;
              shreg    <= regs[ptr];
              o_sda_oe <= ~regs[ptr][DW-1];
              state    <= S_RDATA;
            end
          end
          S_WAIT_STOP: o_sda_oe <= 1'b0;
          default:     state    <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on an open-drain SDA.
module tb_i2c_target_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       bus_sda;
  logic       sda_oe, busy, start_det, stop_det, wr_en;
  logic [2:0] wr_ptr;
  logic [7:0] wr_data;

  assign bus_sda = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.P_ADDR(7'h2A)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .i_sda(bus_sda),
    .o_sda_oe(sda_oe), .o_busy(busy), .o_start_det(start_det), .o_stop_det(stop_det),
    .o_wr_en(wr_en), .o_wr_ptr(wr_ptr), .o_wr_data(wr_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int n_start = 0;
  int n_stop = 0;
  int oe_cnt = 0;
  logic [2:0] wq_ptr[$];
  logic [7:0] wq_data[$];
  int         wq_lat[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe) oe_cnt++;
    if (wr_en) begin
      wq_ptr.push_back(wr_ptr);
      wq_data.push_back(wr_data);
      wq_lat.push_back(cyc - rise_cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_clk(input logic b, output logic s, output logic oe);
    sda_m = b;
    q();
    scl = 1'b1;
    rise_cyc = cyc;
    q();
    s  = bus_sda;
    oe = sda_oe;
    q();
    scl = 1'b0;
    q();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl = 1'b1;   q();
    sda_m = 1'b0; q();
    scl = 1'b0;   q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl = 1'b1;   q();
    sda_m = 1'b1; q();
    q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s, oe;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], s, oe);
    bit_clk(1'b1, s, oe);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
    logic s, oe;
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      bit_clk(1'b1, s, oe);
      t = {t[6:0], s};
    end
    bit_clk(~mack, s, oe_ack);
    d = t;
  endtask

  typedef struct {
    bit         rd;
    bit         set_ptr;
    logic [7:0] addr;
    logic [7:0] ptr;
    logic [7:0] d0, d1;
    bit         exp_ack;
    int         exp_nwr;
    logic [2:0] ep0, ep1;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vec_t v;
    logic ack, oea;
    logic [7:0] d;
    int s_start, s_stop, s_oe, head, s_head;
    logic s, oe;

    // write vectors: ep/e hold expected strobes; read vectors: e holds expected data
    vecs[0] = '{0, 1, 8'h54, 8'h05, 8'h77, 8'h66, 1, 2, 3'd5, 3'd6, 8'h77, 8'h66};
    vecs[1] = '{0, 1, 8'h54, 8'h03, 8'hA5, 8'h5A, 1, 2, 3'd3, 3'd4, 8'hA5, 8'h5A};
    vecs[2] = '{1, 0, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 3'd0, 3'd0, 8'h77, 8'h66};
    vecs[3] = '{1, 1, 8'h55, 8'h03, 8'h00, 8'h00, 1, 0, 3'd0, 3'd0, 8'hA5, 8'h5A};
    vecs[4] = '{0, 1, 8'h56, 8'h11, 8'h00, 8'h00, 0, 0, 3'd0, 3'd0, 8'h00, 8'h00};
    vecs[5] = '{0, 1, 8'h54, 8'h07, 8'h11, 8'h22, 1, 2, 3'd7, 3'd0, 8'h11, 8'h22};
    vecs[6] = '{1, 1, 8'h55, 8'h07, 8'h00, 8'h00, 1, 0, 3'd0, 3'd0, 8'h11, 8'h22};

    repeat (4) @(posedge clk);
    #1;
    chk("reset_oe", sda_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {start_det, stop_det, wr_en}, 0);
    chk("reset_wr_bus", {wr_ptr, wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q();
    head = 0;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      s_start = n_start;
      s_stop  = n_stop;
      s_oe    = oe_cnt;
      s_head  = wq_ptr.size();
      bus_start();
      chk($sformatf("v%0d_busy_in", i), busy, 1);
      if (!v.rd) begin
        send_byte(v.addr, ack);
        chk($sformatf("v%0d_addr_ack", i), ack, v.exp_ack);
        send_byte(v.ptr, ack);
        chk($sformatf("v%0d_ptr_ack", i), ack, v.exp_ack);
        if (v.exp_ack) begin
          send_byte(v.d0, ack);
          chk($sformatf("v%0d_d0_ack", i), ack, 1);
          send_byte(v.d1, ack);
          chk($sformatf("v%0d_d1_ack", i), ack, 1);
        end
        bus_stop();
        if (!v.exp_ack) chk($sformatf("v%0d_oe_quiet", i), oe_cnt - s_oe, 0);
      end else begin
        if (v.set_ptr) begin
          send_byte(8'h54, ack);
          chk($sformatf("v%0d_wa_ack", i), ack, 1);
          send_byte(v.ptr, ack);
          chk($sformatf("v%0d_ptr_ack", i), ack, 1);
          bus_start();
        end
        send_byte(v.addr, ack);
        chk($sformatf("v%0d_ra_ack", i), ack, 1);
        recv_byte(1'b1, d, oea);
        chk($sformatf("v%0d_rd0", i), d, v.e0);
        chk($sformatf("v%0d_mack_oe", i), oea, 0);
        recv_byte(1'b0, d, oea);
        chk($sformatf("v%0d_rd1", i), d, v.e1);
        chk($sformatf("v%0d_mnack_oe", i), oea, 0);
        bus_stop();
      end
      chk($sformatf("v%0d_nwr", i), wq_ptr.size() - s_head, v.exp_nwr);
      if (v.exp_nwr == 2 && wq_ptr.size() - s_head == 2) begin
        chk($sformatf("v%0d_wr0", i), {wq_ptr[s_head], wq_data[s_head]}, {v.ep0, v.e0});
        chk($sformatf("v%0d_wr1", i), {wq_ptr[s_head+1], wq_data[s_head+1]}, {v.ep1, v.e1});
      end
      chk($sformatf("v%0d_starts", i), n_start - s_start, (v.rd && v.set_ptr) ? 2 : 1);
      chk($sformatf("v%0d_stops", i), n_stop - s_stop, 1);
      chk($sformatf("v%0d_busy_out", i), busy, 0);
    end

    for (int i = 0; i < wq_lat.size(); i++) chk($sformatf("wr_latency%0d", i), wq_lat[i], 4);

    // STOP after four data bits: nothing committed, pointer stays at 6.
    s_head = wq_ptr.size();
    s_stop = n_stop;
    bus_start();
    send_byte(8'h54, ack);
    chk("trunc_addr_ack", ack, 1);
    send_byte(8'h06, ack);
    chk("trunc_ptr_ack", ack, 1);
    bit_clk(1'b1, s, oe); bit_clk(1'b0, s, oe); bit_clk(1'b1, s, oe); bit_clk(1'b0, s, oe);
    bus_stop();
    repeat (8) @(posedge clk);
    #1;
    chk("trunc_no_wr", wq_ptr.size() - s_head, 0);
    chk("trunc_stop", n_stop - s_stop, 1);
    bus_start();
    send_byte(8'h55, ack);
    chk("trunc_idle_ack", ack, 1);
    recv_byte(1'b0, d, oea);
    chk("trunc_ptr_kept", d, 8'h66);
    bus_stop();

    // Reset while the target is pulling SDA low for bit 6 of 0xA5.
    bus_start();
    send_byte(8'h54, ack);
    send_byte(8'h03, ack);
    bus_start();
    send_byte(8'h55, ack);
    chk("rst_rd_ack", ack, 1);
    bit_clk(1'b1, s, oe);
    chk("rst_bit7", s, 1);
    chk("rst_oe_driving", sda_oe, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_oe_async", sda_oe, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sda_m = 1'b1;
    q();
    bus_start();
    send_byte(8'h55, ack);
    chk("post_rst_ack", ack, 1);
    recv_byte(1'b0, d, oea);
    chk("post_rst_ptr0", d, 8'h00);
    bus_stop();
    bus_start();
    send_byte(8'h54, ack);
    send_byte(8'h03, ack);
    bus_start();
    send_byte(8'h55, ack);
    recv_byte(1'b0, d, oea);
    chk("post_rst_reg3", d, 8'h00);
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
